btn_conditioner: RTL and testbench

BTN_CONDITIONER -- requirements
Module: btn_conditioner

---
 rtl/btn_conditioner.sv | 154 +++++++++++++++
 tb/tb_btn_conditioner.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// Four-channel button conditioner: 2-flop synchronizer, debounce, press/auto-repeat
// pulse generation and sticky pending flags consumed by a slow game tick.
module btn_conditioner #(
    parameter int unsigned DB_CYCLES  = 1000000,
    parameter int unsigned RPT_DELAY  = 40000000,
    parameter int unsigned RPT_PERIOD = 10000000,
    parameter logic [3:0]  RPT_EN     = 4'b0111
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] BtnRaw,
    input  logic       Ack,
    output logic [3:0] BtnLevel,
    output logic [3:0] BtnPulse,
    output logic [3:0] BtnPend
);

    localparam int unsigned DBW = $clog2(DB_CYCLES + 32'd1);
    // The accept point sits one count past DB_CYCLES-1 so a press shows up
    // DB_CYCLES+2 edges after BtnRaw is first sampled high.
    localparam logic [DBW-1:0] DB_TERM  = DBW'(DB_CYCLES);
    localparam logic [26:0]    DLY_TERM = 27'(RPT_DELAY - 32'd1);
    localparam logic [26:0]    PER_TERM = 27'(RPT_PERIOD - 32'd1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2,
        HOLD   = 2'd3
    } state_t;

    logic [3:0]     sync1_q, sync1_d;
    logic [3:0]     sync2_q, sync2_d;
    logic [3:0]     level_q, level_d;
    logic [3:0]     pulse_q, pulse_d;
    logic [3:0]     pend_q,  pend_d;
    logic [DBW-1:0] db_cnt_q  [4];
    logic [DBW-1:0] db_cnt_d  [4];
    logic [26:0]    rpt_cnt_q [4];
    logic [26:0]    rpt_cnt_d [4];
    state_t         state_q   [4];
    state_t         state_d   [4];

    // State register for synchronizers, debounce, repeat FSMs and flags.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1_q <= 4'b0000;
            sync2_q <= 4'b0000;
            level_q <= 4'b0000;
            pulse_q <= 4'b0000;
            pend_q  <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i]  <= {DBW{1'b0}};
                rpt_cnt_q[i] <= 27'd0;
                state_q[i]   <= IDLE;
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            pend_q  <= pend_d;
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i]  <= db_cnt_d[i];
                rpt_cnt_q[i] <= rpt_cnt_d[i];
                state_q[i]   <= state_d[i];
            end
        end
    end

    // Per-channel debounce, repeat FSM and pending-flag next-state logic.
    always_comb begin
        sync1_d = BtnRaw;
        sync2_d = sync1_q;
        level_d = level_q;
        pulse_d = 4'b0000;
        pend_d  = pend_q;
        for (int i = 0; i < 4; i++) begin
            db_cnt_d[i]  = db_cnt_q[i];
            rpt_cnt_d[i] = rpt_cnt_q[i];
            state_d[i]   = state_q[i];

            if (sync2_q[i] == level_q[i]) begin
                db_cnt_d[i] = {DBW{1'b0}};
            end else if (db_cnt_q[i] == DB_TERM) begin
                level_d[i]  = sync2_q[i];
                db_cnt_d[i] = {DBW{1'b0}};
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + {{(DBW-1){1'b0}}, 1'b1};
            end

            case (state_q[i])
                IDLE: begin
                    rpt_cnt_d[i] = 27'd0;
                    if (level_q[i]) begin
                        pulse_d[i] = 1'b1;
                        state_d[i] = RPT_EN[i] ? DELAY : HOLD;
                    end else begin
                        state_d[i] = IDLE;
                    end
                end
                DELAY: begin
                    if (!level_q[i]) begin
                        state_d[i]   = IDLE;
                        rpt_cnt_d[i] = 27'd0;
                    end else if (rpt_cnt_q[i] == DLY_TERM) begin
                        pulse_d[i]   = 1'b1;
                        state_d[i]   = REPEAT;
                        rpt_cnt_d[i] = 27'd0;
                    end else begin
                        rpt_cnt_d[i] = rpt_cnt_q[i] + 27'd1;
                    end
                end
                REPEAT: begin
                    if (!level_q[i]) begin
                        state_d[i]   = IDLE;
                        rpt_cnt_d[i] = 27'd0;
                    end else if (rpt_cnt_q[i] == PER_TERM) begin
                        pulse_d[i]   = 1'b1;
                        rpt_cnt_d[i] = 27'd0;
                    end else begin
                        rpt_cnt_d[i] = rpt_cnt_q[i] + 27'd1;
                    end
                end
                HOLD: begin
                    rpt_cnt_d[i] = 27'd0;
                    if (!level_q[i]) begin
                        state_d[i] = IDLE;
                    end else begin
                        state_d[i] = HOLD;
                    end
                end
                default: begin
                    state_d[i]   = IDLE;
                    rpt_cnt_d[i] = 27'd0;
                end
            endcase

            // A pulse landing together with Ack must not be lost.
            if (pulse_q[i]) begin
                pend_d[i] = 1'b1;
            end else if (Ack) begin
                pend_d[i] = 1'b0;
            end else begin
                pend_d[i] = pend_q[i];
            end
        end
    end

    assign BtnLevel = level_q;
    assign BtnPulse = pulse_q;
    assign BtnPend  = pend_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner: expected pulse edges go into a scoreboard
// queue as stimulus is applied and are compared against per-edge output logs.
module tb_btn_conditioner;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [3:0] BtnRaw = 4'b0000;
    logic       Ack = 1'b0;
    logic [3:0] BtnLevel, BtnPulse, BtnPend;

    btn_conditioner #(
        .DB_CYCLES (4),
        .RPT_DELAY (20),
        .RPT_PERIOD(8),
        .RPT_EN    (4'b0111)
    ) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .BtnRaw  (BtnRaw),
        .Ack     (Ack),
        .BtnLevel(BtnLevel),
        .BtnPulse(BtnPulse),
        .BtnPend (BtnPend)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int         edge_n;
        logic [3:0] mask;
    } exp_t;

    exp_t       exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         edge_cnt = 0;
    logic [3:0] pulse_log [2048];
    logic [3:0] level_log [2048];
    logic [3:0] pend_log  [2048];

    // Count rising clock edges; edge_cnt names the most recent one.
    always @(posedge Clk) edge_cnt <= edge_cnt + 1;

    // Record outputs on the falling edge, indexed by the rising edge that produced them.
    always @(negedge Clk) begin
        pulse_log[edge_cnt[10:0]] <= BtnPulse;
        level_log[edge_cnt[10:0]] <= BtnLevel;
        pend_log[edge_cnt[10:0]]  <= BtnPend;
    end

    task automatic at_edge(input int e);
        while (edge_cnt < e - 1) @(negedge Clk);
    endtask

    task automatic wait_past(input int e);
        while (edge_cnt <= e) @(negedge Clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge Clk);
        n_vec++;
        if ({BtnLevel, BtnPulse, BtnPend} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_hold: got %h want 000", {BtnLevel, BtnPulse, BtnPend});
        end
        Reset = 1'b0;
        repeat (10) @(negedge Clk);
        n_vec++;
        if ({BtnLevel, BtnPulse, BtnPend} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_idle: got %h want 000", {BtnLevel, BtnPulse, BtnPend});
        end
    endtask

    task automatic test_press_repeat();
        int   e0;
        exp_t x;
        e0 = edge_cnt + 1;
        BtnRaw[1] = 1'b1;
        x.mask = 4'b0010;
        x.edge_n = e0 + 7;
        exp_q.push_back(x);
        for (int k = 0; k < 10; k++) begin
            x.edge_n = e0 + 27 + 8 * k;
            exp_q.push_back(x);
        end
        at_edge(e0 + 100);
        BtnRaw[1] = 1'b0;
        wait_past(e0 + 130);
        n_vec++;
        if ({level_log[11'(e0 + 5)][1], level_log[11'(e0 + 6)][1],
             level_log[11'(e0 + 105)][1], level_log[11'(e0 + 106)][1]} !== 4'b0110) begin
            n_err++;
            $display("FAIL press_level_edges: got %b want 0110",
                     {level_log[11'(e0 + 5)][1], level_log[11'(e0 + 6)][1],
                      level_log[11'(e0 + 105)][1], level_log[11'(e0 + 106)][1]});
        end
        n_vec++;
        if ({pend_log[11'(e0 + 7)][1], pend_log[11'(e0 + 8)][1]} !== 2'b01) begin
            n_err++;
            $display("FAIL press_pend_set: got %b want 01",
                     {pend_log[11'(e0 + 7)][1], pend_log[11'(e0 + 8)][1]});
        end
        for (int e = e0; e <= e0 + 130; e++) begin
            logic [3:0] want;
            want = 4'b0000;
            if (exp_q.size() > 0 && exp_q[0].edge_n == e) begin
                want = exp_q[0].mask;
                void'(exp_q.pop_front());
            end
            n_vec++;
            if (pulse_log[11'(e)] !== want) begin
                n_err++;
                $display("FAIL press_pulse@%0d: got %b want %b", e - e0, pulse_log[11'(e)], want);
            end
        end
        Ack = 1'b1;
        @(negedge Clk);
        Ack = 1'b0;
        @(negedge Clk);
        n_vec++;
        if (BtnPend !== 4'b0000) begin
            n_err++;
            $display("FAIL press_ack_clear: got %b want 0000", BtnPend);
        end
    endtask

    task automatic test_no_repeat();
        int   e0;
        exp_t x;
        e0 = edge_cnt + 1;
        BtnRaw[3] = 1'b1;
        x.mask = 4'b1000;
        x.edge_n = e0 + 7;
        exp_q.push_back(x);
        at_edge(e0 + 100);
        BtnRaw[3] = 1'b0;
        wait_past(e0 + 115);
        n_vec++;
        if ({pend_log[11'(e0 + 8)][3], pend_log[11'(e0 + 99)][3], BtnPend} !== 6'b111000) begin
            n_err++;
            $display("FAIL hold_pend_sticky: got %b want 111000",
                     {pend_log[11'(e0 + 8)][3], pend_log[11'(e0 + 99)][3], BtnPend});
        end
        for (int e = e0; e <= e0 + 115; e++) begin
            logic [3:0] want;
            want = 4'b0000;
            if (exp_q.size() > 0 && exp_q[0].edge_n == e) begin
                want = exp_q[0].mask;
                void'(exp_q.pop_front());
            end
            n_vec++;
            if (pulse_log[11'(e)] !== want) begin
                n_err++;
                $display("FAIL hold_pulse@%0d: got %b want %b", e - e0, pulse_log[11'(e)], want);
            end
        end
        Ack = 1'b1;
        @(negedge Clk);
        Ack = 1'b0;
        @(negedge Clk);
        n_vec++;
        if (BtnPend !== 4'b0000) begin
            n_err++;
            $display("FAIL hold_ack_clear: got %b want 0000", BtnPend);
        end
    endtask

    task automatic test_glitch();
        int e0;
        e0 = edge_cnt + 1;
        BtnRaw[0] = 1'b1;
        at_edge(e0 + 3);
        BtnRaw[0] = 1'b0;
        wait_past(e0 + 20);
        for (int e = e0; e <= e0 + 20; e++) begin
            n_vec++;
            if ({level_log[11'(e)][0], pulse_log[11'(e)][0], pend_log[11'(e)][0]} !== 3'b000) begin
                n_err++;
                $display("FAIL glitch@%0d: level/pulse/pend got %b want 000", e - e0,
                         {level_log[11'(e)][0], pulse_log[11'(e)][0], pend_log[11'(e)][0]});
            end
        end
    endtask

    task automatic test_ack_collision();
        int   e0;
        exp_t x;
        e0 = edge_cnt + 1;
        BtnRaw[2] = 1'b1;
        x.mask = 4'b0100;
        x.edge_n = e0 + 7;
        exp_q.push_back(x);
        at_edge(e0 + 8);
        Ack = 1'b1;
        n_vec++;
        if (BtnPulse !== 4'b0100) begin
            n_err++;
            $display("FAIL collide_pulse_now: got %b want 0100", BtnPulse);
        end
        at_edge(e0 + 9);
        Ack = 1'b0;
        at_edge(e0 + 10);
        BtnRaw[2] = 1'b0;
        at_edge(e0 + 40);
        Ack = 1'b1;
        at_edge(e0 + 41);
        Ack = 1'b0;
        wait_past(e0 + 45);
        n_vec++;
        if ({pend_log[11'(e0 + 8)][2], pend_log[11'(e0 + 39)][2], pend_log[11'(e0 + 40)][2]} !== 3'b110) begin
            n_err++;
            $display("FAIL collide_pend: got %b want 110",
                     {pend_log[11'(e0 + 8)][2], pend_log[11'(e0 + 39)][2], pend_log[11'(e0 + 40)][2]});
        end
        for (int e = e0; e <= e0 + 45; e++) begin
            logic [3:0] want;
            want = 4'b0000;
            if (exp_q.size() > 0 && exp_q[0].edge_n == e) begin
                want = exp_q[0].mask;
                void'(exp_q.pop_front());
            end
            n_vec++;
            if (pulse_log[11'(e)] !== want) begin
                n_err++;
                $display("FAIL collide_pulse@%0d: got %b want %b", e - e0, pulse_log[11'(e)], want);
            end
        end
    endtask

    task automatic test_reset_mid_delay();
        int   e0;
        int   e1;
        exp_t x;
        e0 = edge_cnt + 1;
        BtnRaw[1] = 1'b1;
        x.mask = 4'b0010;
        x.edge_n = e0 + 7;
        exp_q.push_back(x);
        at_edge(e0 + 15);
        Reset = 1'b1;
        #1;
        n_vec++;
        if ({BtnLevel, BtnPulse, BtnPend} !== 12'h000) begin
            n_err++;
            $display("FAIL midreset_async: got %h want 000", {BtnLevel, BtnPulse, BtnPend});
        end
        at_edge(e0 + 17);
        Reset = 1'b0;
        e1 = e0 + 17;
        x.edge_n = e1 + 7;
        exp_q.push_back(x);
        at_edge(e1 + 10);
        BtnRaw[1] = 1'b0;
        wait_past(e1 + 35);
        n_vec++;
        if ({level_log[11'(e1 + 5)][1], level_log[11'(e1 + 6)][1]} !== 2'b01) begin
            n_err++;
            $display("FAIL midreset_redebounce: got %b want 01",
                     {level_log[11'(e1 + 5)][1], level_log[11'(e1 + 6)][1]});
        end
        for (int e = e0; e <= e1 + 35; e++) begin
            logic [3:0] want;
            want = 4'b0000;
            if (exp_q.size() > 0 && exp_q[0].edge_n == e) begin
                want = exp_q[0].mask;
                void'(exp_q.pop_front());
            end
            n_vec++;
            if (pulse_log[11'(e)] !== want) begin
                n_err++;
                $display("FAIL midreset_pulse@%0d: got %b want %b", e - e0, pulse_log[11'(e)], want);
            end
        end
        Ack = 1'b1;
        @(negedge Clk);
        Ack = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_simultaneous();
        int   e0;
        exp_t x;
        e0 = edge_cnt + 1;
        BtnRaw = 4'b1111;
        x.mask = 4'b1111;
        x.edge_n = e0 + 7;
        exp_q.push_back(x);
        at_edge(e0 + 10);
        BtnRaw = 4'b0000;
        wait_past(e0 + 25);
        for (int e = e0; e <= e0 + 25; e++) begin
            logic [3:0] want;
            want = 4'b0000;
            if (exp_q.size() > 0 && exp_q[0].edge_n == e) begin
                want = exp_q[0].mask;
                void'(exp_q.pop_front());
            end
            n_vec++;
            if (pulse_log[11'(e)] !== want) begin
                n_err++;
                $display("FAIL all_pulse@%0d: got %b want %b", e - e0, pulse_log[11'(e)], want);
            end
        end
        n_vec++;
        if (BtnPend !== 4'b1111) begin
            n_err++;
            $display("FAIL all_pend: got %b want 1111", BtnPend);
        end
        Ack = 1'b1;
        @(negedge Clk);
        Ack = 1'b0;
        @(negedge Clk);
        n_vec++;
        if (BtnPend !== 4'b0000) begin
            n_err++;
            $display("FAIL all_ack_clear: got %b want 0000", BtnPend);
        end
    endtask

    initial begin
        test_reset();
        test_press_repeat();
        test_no_repeat();
        test_glitch();
        test_ack_collision();
        test_reset_mid_delay();
        test_simultaneous();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d leftover want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
